// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: instruction fetch stage for the single-issue MIPS core.
// Holds the PC, issues one word read at a time to instruction memory over a
// request/grant/response handshake, and presents the result in the IF/ID
// output register. A redirect from execute flushes the output register and
// discards any response still in flight.
//
// Optional feature: define IFU_PERF_CNT_EN to add the perf_fetched and
// perf_stall counter ports.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   imem_req, imem_addr           read request and word-aligned address
//   imem_gnt                      request accepted this cycle
//   imem_rvalid, imem_rdata       read response (in order, one per grant)
//   id_ready                      decode consumes the output register
//   redirect, redirect_pc         taken branch/jump and its target
//   ifid_valid, ifid_instr        IF/ID output register
//   ifid_opcode                   ifid_instr[31:26] for the main decoder
//   ifid_pc4                      fetched instruction address + 4
//   perf_fetched, perf_stall      (IFU_PERF_CNT_EN only) wrapping counters
//
// state   | meaning
// --------+---------------------------------------------
// S_RESET | rst_n low; no request issued
// S_FETCH | request driven when the output register is free
// S_WAIT  | one request outstanding, waiting for imem_rvalid

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        id_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [5:0]  ifid_opcode,
`ifdef IFU_PERF_CNT_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall,
`endif
  output logic [31:0] ifid_pc4
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc;
  logic [31:0] pc_inc;
  logic [31:0] target;
  logic        kill;
  logic        kill_next;
  logic        issue_ok;
  logic        load;

  assign issue_ok  = !ifid_valid || id_ready;
  assign pc_inc    = pc + 32'd4;
  assign target    = redirect_pc & 32'hFFFF_FFFC;
  assign imem_addr = pc;
  assign ifid_opcode = ifid_instr[31:26];

  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    case (state)
      S_RESET: state_next = S_FETCH;
      S_FETCH: begin
        imem_req = issue_ok;
        if (issue_ok && imem_gnt) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // A response loads only when it is not the killed one and no redirect
  // is arriving in the same cycle (the redirect makes it wrong-path).
  assign load = (state == S_WAIT) && imem_rvalid && !kill && !redirect;

  // kill marks the single outstanding request as wrong-path. It is set when
  // a redirect leaves a request in flight and cleared when that response
  // returns; a redirect coinciding with the response itself leaves it clear.
  always_comb begin
    kill_next = kill;
    if ((state == S_WAIT) && imem_rvalid) kill_next = 1'b0;
    if (redirect) begin
      kill_next = ((state == S_WAIT) && !imem_rvalid && 1'b1)
                  || ((state == S_FETCH) && imem_req && imem_gnt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RESET;
      kill  <= 1'b0;
    end else begin
      state <= state_next;
      kill  <= kill_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      ifid_valid <= 1'b0;
      ifid_instr <= 32'h0;
      ifid_pc4   <= 32'h0;
    end else if (redirect) begin
      pc         <= target;
      ifid_valid <= 1'b0;
    end else if (load) begin
      pc         <= pc_inc;
      ifid_valid <= 1'b1;
      ifid_instr <= imem_rdata;
      ifid_pc4   <= pc_inc;
    end else if (id_ready && ifid_valid) begin
      ifid_valid <= 1'b0;
    end
  end

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= 32'h0;
      perf_stall   <= 32'h0;
    end else begin
      if (load) perf_fetched <= perf_fetched + 32'd1;
      if (ifid_valid && !id_ready) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [5:0]  ifid_opcode;
  logic [31:0] ifid_pc4;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_ready    (id_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ifid_valid  (ifid_valid),
    .ifid_instr  (ifid_instr),
    .ifid_opcode (ifid_opcode),
`ifdef IFU_PERF_CNT_EN
    .perf_fetched(perf_fetched),
    .perf_stall  (perf_stall),
`endif
    .ifid_pc4    (ifid_pc4)
  );

  typedef struct {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc4;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(logic gnt, logic rvalid, logic [31:0] rdata,
                              logic rdy, logic redir, logic [31:0] rpc,
                              logic req, logic [31:0] addr, logic v,
                              logic [31:0] instr, logic [31:0] pc4);
    vec_t r;
    r.gnt = gnt; r.rvalid = rvalid; r.rdata = rdata; r.rdy = rdy;
    r.redir = redir; r.rpc = rpc; r.req = req; r.addr = addr; r.v = v;
    r.instr = instr; r.pc4 = pc4;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic req, input logic [31:0] addr,
                          input logic v, input logic [31:0] instr, input logic [31:0] pc4);
    logic [31:0] op_exp;
    op_exp = {26'h0, instr[31:26]};
    chk({tag, " imem_req"},    {31'h0, imem_req},    {31'h0, req});
    chk({tag, " imem_addr"},   imem_addr,            addr);
    chk({tag, " ifid_valid"},  {31'h0, ifid_valid},  {31'h0, v});
    chk({tag, " ifid_instr"},  ifid_instr,           instr);
    chk({tag, " ifid_opcode"}, {26'h0, ifid_opcode}, op_exp);
    chk({tag, " ifid_pc4"},    ifid_pc4,             pc4);
  endtask

  initial begin
    //              gnt rv rdata          rdy rd rpc            req addr           v  instr          pc4
    tbl[0]  = mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0040_0000, 0, 32'h0,          32'h0);
    tbl[1]  = mk(1, 1, 32'h8C01_0004,  1, 0, 32'h0,          0, 32'h0040_0000, 0, 32'h0,          32'h0);
    tbl[2]  = mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0040_0004, 1, 32'h8C01_0004,  32'h0040_0004);
    tbl[3]  = mk(1, 1, 32'h0800_0010,  1, 0, 32'h0,          0, 32'h0040_0004, 0, 32'h8C01_0004,  32'h0040_0004);
    // id_ready low for 5 cycles: no request, output stable
    tbl[4]  = mk(1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0040_0008, 1, 32'h0800_0010,  32'h0040_0008);
    tbl[5]  = tbl[4];
    tbl[6]  = tbl[4];
    tbl[7]  = tbl[4];
    tbl[8]  = tbl[4];
    tbl[9]  = mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0040_0008, 1, 32'h0800_0010,  32'h0040_0008);
    tbl[10] = mk(0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0040_0008, 0, 32'h0800_0010,  32'h0040_0008);
    // redirect while waiting, then the killed response
    tbl[11] = mk(0, 0, 32'h0,          1, 1, 32'h0000_1003,  0, 32'h0040_0008, 0, 32'h0800_0010,  32'h0040_0008);
    tbl[12] = mk(0, 1, 32'hDEAD_BEEF,  1, 0, 32'h0,          0, 32'h0000_1000, 0, 32'h0800_0010,  32'h0040_0008);
    tbl[13] = mk(0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_1000, 0, 32'h0800_0010,  32'h0040_0008);
    // redirect in the grant cycle
    tbl[14] = mk(1, 0, 32'h0,          1, 1, 32'h0000_2000,  1, 32'h0000_1000, 0, 32'h0800_0010,  32'h0040_0008);
    tbl[15] = mk(0, 1, 32'h1111_1111,  1, 0, 32'h0,          0, 32'h0000_2000, 0, 32'h0800_0010,  32'h0040_0008);
    tbl[16] = mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_2000, 0, 32'h0800_0010,  32'h0040_0008);
    // redirect coincident with rvalid; then fetch at the wrap boundary
    tbl[17] = mk(0, 1, 32'h2222_2222,  1, 1, 32'hFFFF_FFFE,  0, 32'h0000_2000, 0, 32'h0800_0010,  32'h0040_0008);
    tbl[18] = mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'hFFFF_FFFC, 0, 32'h0800_0010,  32'h0040_0008);
    tbl[19] = mk(0, 1, 32'h3C1F_0000,  1, 0, 32'h0,          0, 32'hFFFF_FFFC, 0, 32'h0800_0010,  32'h0040_0008);
    tbl[20] = mk(0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0000_0000, 1, 32'h3C1F_0000,  32'h0000_0000);
    tbl[21] = mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_0000, 1, 32'h3C1F_0000,  32'h0000_0000);
    tbl[22] = mk(0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0000_0000, 0, 32'h3C1F_0000,  32'h0000_0000);

    rst_n = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    id_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

    @(negedge clk);
    @(negedge clk);
    #1;
    chk_outs("reset", 1'b0, RST_PC, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      imem_gnt    = tbl[i].gnt;
      imem_rvalid = tbl[i].rvalid;
      imem_rdata  = tbl[i].rdata;
      id_ready    = tbl[i].rdy;
      redirect    = tbl[i].redir;
      redirect_pc = tbl[i].rpc;
      #1;
      chk_outs($sformatf("c%0d", i), tbl[i].req, tbl[i].addr, tbl[i].v,
               tbl[i].instr, tbl[i].pc4);
    end

`ifdef IFU_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, 32'd3);
    chk("perf_stall",   perf_stall,   32'd6);
`endif

    // asynchronous reset in the middle of an outstanding fetch
    #1;
    rst_n = 1'b0;
    #1;
    chk_outs("async_rst", 1'b0, RST_PC, 1'b0, 32'h0, 32'h0);
    imem_gnt = 1'b1; imem_rvalid = 1'b0; id_ready = 1'b1; redirect = 1'b0;
    @(negedge clk);
    #1;
    chk_outs("rst_held", 1'b0, RST_PC, 1'b0, 32'h0, 32'h0);
`ifdef IFU_PERF_CNT_EN
    chk("perf_fetched_rst", perf_fetched, 32'd0);
    chk("perf_stall_rst",   perf_stall,   32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk_outs("restart", 1'b1, RST_PC, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    imem_rvalid = 1'b1; imem_rdata = 32'hAC22_0008; imem_gnt = 1'b0;
    #1;
    chk_outs("restart_wait", 1'b0, RST_PC, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    imem_rvalid = 1'b0; id_ready = 1'b0;
    #1;
    chk_outs("restart_load", 1'b0, RST_PC + 32'd4, 1'b1, 32'hAC22_0008, RST_PC + 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
